// File: rtl/fg_cfg_writer_if.sv
// Config-register write bus between a host and fg_cfg_writer.
// Ports: start_i/cfg_i/mask_i carry the request in; data_o/addr_o/wr_en_o/busy_o/done_o carry the bus and status out.
interface fg_cfg_writer_if #(
   parameter int CFG_W = 64
);

   logic             start_i;
   logic [CFG_W-1:0] cfg_i;
   logic [7:0]       mask_i;
   logic [7:0]       data_o;
   logic [2:0]       addr_o;
   logic             wr_en_o;
   logic             busy_o;
   logic             done_o;

   modport master (
      input  start_i,
      input  cfg_i,
      input  mask_i,
      output data_o,
      output addr_o,
      output wr_en_o,
      output busy_o,
      output done_o
   );

   modport slave (
      output start_i,
      output cfg_i,
      output mask_i,
      input  data_o,
      input  addr_o,
      input  wr_en_o,
      input  busy_o,
      input  done_o
   );

endinterface

// File: rtl/fg_cfg_writer.sv
// Serialises a masked 8x8 config image into byte writes on the generator's config bus.
// Ports: clk_i, rstn_i (sync, active low); bus.master = start/cfg/mask in, data/addr/wr_en/busy/done out.
module fg_cfg_writer #(
   parameter int CONFIG_REG_BITWIDTH = 64,
   parameter int SETUP_CYCLES        = 2,
   parameter int STROBE_CYCLES       = 4,
   parameter int HOLD_CYCLES         = 2
) (
   input logic             clk_i,
   input logic             rstn_i,
   fg_cfg_writer_if.master bus
);

   localparam int MAX_SW =
      (SETUP_CYCLES > STROBE_CYCLES) ?
      SETUP_CYCLES : STROBE_CYCLES;
   localparam int MAX_C =
      (MAX_SW > HOLD_CYCLES) ?
      MAX_SW : HOLD_CYCLES;
   localparam int CW = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] S_LD =
      CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] W_LD =
      CW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] H_LD =
      CW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_FINISH
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CONFIG_REG_BITWIDTH-1:0] img_q, img_d;
   logic [7:0] pend_q, pend_d;
   logic [7:0] data_q, data_d;
   logic [2:0] addr_q, addr_d;
   logic       wr_en_q, wr_en_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic [2:0] cap_k;
   logic [2:0] nxt_k;

   function automatic logic [2:0] lowest(
      input logic [7:0] m
   );
      lowest = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) lowest = 3'(i);
      end
   endfunction

   // CR0 sits in the top byte, so byte k
   // starts at bit 8*(7-k) = {~k,3'b000}.
   function automatic logic [7:0] byte_of(
      input logic [CONFIG_REG_BITWIDTH-1:0] img,
      input logic [2:0]                     k
   );
      byte_of = img[{~k, 3'b000} +: 8];
   endfunction

   assign cap_k = lowest(bus.mask_i);
   assign nxt_k = lowest(pend_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      img_d   = img_q;
      pend_d  = pend_q;
      data_d  = data_q;
      addr_d  = addr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               img_d = bus.cfg_i;
               if (|bus.mask_i) begin
                  state_d = ST_SETUP;
                  cnt_d   = S_LD;
                  addr_d  = cap_k;
                  data_d  = byte_of(bus.cfg_i, cap_k);
                  // pend holds registers still to write
                  pend_d  = bus.mask_i
                          & ~(8'd1 << cap_k);
               end else begin
                  pend_d  = 8'd0;
                  state_d = ST_FINISH;
               end
            end
         end

         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_STROBE;
               cnt_d   = W_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_STROBE: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
               cnt_d   = H_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_HOLD: begin
            if (cnt_q == '0) begin
               if (|pend_q) begin
                  state_d = ST_SETUP;
                  cnt_d   = S_LD;
                  addr_d  = nxt_k;
                  data_d  = byte_of(img_q, nxt_k);
                  pend_d  = pend_q
                          & ~(8'd1 << nxt_k);
               end else begin
                  state_d = ST_FINISH;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_FINISH: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status flags are registered from the
      // next state so they never glitch.
      wr_en_d = (state_d == ST_STROBE);
      busy_d  = (state_d == ST_SETUP)
             || (state_d == ST_STROBE)
             || (state_d == ST_HOLD);
      done_d  = (state_d == ST_FINISH);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         img_q   <= '0;
         pend_q  <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         wr_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         img_q   <= img_d;
         pend_q  <= pend_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         wr_en_q <= wr_en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.data_o  = data_q;
   assign bus.addr_o  = addr_q;
   assign bus.wr_en_o = wr_en_q;
   assign bus.busy_o  = busy_q;
   assign bus.done_o  = done_q;

endmodule

// File: tb/tb_fg_cfg_writer.sv
// Directed bench for fg_cfg_writer.
// Default instance plus a 1/3/1 timing instance.
module tb_fg_cfg_writer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic [63:0] cfg;
   logic [7:0]  mask;
   bit          sel;

   always #5 clk = ~clk;

   fg_cfg_writer_if bus0 ();
   fg_cfg_writer_if bus1 ();

   assign bus0.start_i = start;
   assign bus0.cfg_i   = cfg;
   assign bus0.mask_i  = mask;
   assign bus1.start_i = start;
   assign bus1.cfg_i   = cfg;
   assign bus1.mask_i  = mask;

   fg_cfg_writer u_dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus0)
   );

   fg_cfg_writer #(
      .SETUP_CYCLES  (1),
      .STROBE_CYCLES (3),
      .HOLD_CYCLES   (1)
   ) u_sweep (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus1)
   );

   logic [7:0] o_data;
   logic [2:0] o_addr;
   logic       o_wr;
   logic       o_busy;
   logic       o_done;

   always_comb begin
      if (sel) begin
         o_data = bus1.data_o;
         o_addr = bus1.addr_o;
         o_wr   = bus1.wr_en_o;
         o_busy = bus1.busy_o;
         o_done = bus1.done_o;
      end else begin
         o_data = bus0.data_o;
         o_addr = bus0.addr_o;
         o_wr   = bus0.wr_en_o;
         o_busy = bus0.busy_o;
         o_done = bus0.done_o;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h",
                  tag, got, exp);
      end
   endtask

   int   np, nbusy, ndone, done_at;
   int   nstray, nunst, width;
   int   wa [8];
   int   wd [8];
   int   rc [8];
   int   pw [8];
   logic prev_wr;

   // Issue one start at the next edge, then
   // observe ncyc cycles at the falling edge.
   task automatic run(
      input logic [63:0] c,
      input logic [7:0]  m,
      input int          ncyc,
      input bit          hold,
      input bit          perturb
   );
      np = 0; nbusy = 0; ndone = 0;
      done_at = -1; nstray = 0; nunst = 0;
      width = 0; prev_wr = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wa[i] = -1; wd[i] = -1;
         rc[i] = -1; pw[i] = -1;
      end
      start = 1'b1;
      cfg   = c;
      mask  = m;
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (perturb) begin
         cfg  = ~c;
         mask = 8'h01;
      end
      for (int t = 1; t <= ncyc; t++) begin
         if (t > 1) @(negedge clk);
         if (o_busy) nbusy++;
         if (o_done) begin
            ndone++;
            done_at = t;
         end
         if (o_wr && !o_busy) nstray++;
         if (o_wr && !prev_wr) begin
            if (np < 8) begin
               wa[np] = int'(o_addr);
               wd[np] = int'(o_data);
               rc[np] = t;
            end
            np++;
            width = 0;
         end
         if (o_wr) begin
            width++;
            if (np >= 1 && np <= 8) begin
               if (int'(o_addr) != wa[np-1] ||
                   int'(o_data) != wd[np-1])
                  nunst++;
            end
         end
         if (!o_wr && prev_wr &&
             np >= 1 && np <= 8)
            pw[np-1] = width;
         prev_wr = o_wr;
      end
      start = 1'b0;
   endtask

   task automatic verify(
      input string       tag,
      input logic [63:0] c,
      input logic [7:0]  m,
      input int          s,
      input int          w,
      input int          h
   );
      int n;
      int slot;
      logic [63:0] eb;
      n    = 0;
      slot = s + w + h;
      for (int k = 0; k < 8; k++) begin
         if (m[k]) begin
            eb = (c >> (56 - 8 * k)) & 64'hFF;
            chk({tag, "_addr"},
                64'(wa[n]), 64'(k));
            chk({tag, "_data"},
                64'(wd[n]), eb);
            chk({tag, "_width"},
                64'(pw[n]), 64'(w));
            chk({tag, "_rise"},
                64'(rc[n]),
                64'(1 + n * slot + s));
            n++;
         end
      end
      chk({tag, "_pulses"},
          64'(np), 64'(n));
      chk({tag, "_busy"},
          64'(nbusy), 64'(n * slot));
      chk({tag, "_ndone"},
          64'(ndone), 64'd1);
      chk({tag, "_done_at"},
          64'(done_at), 64'(n * slot + 1));
      chk({tag, "_stable"},
          64'(nunst), 64'd0);
      chk({tag, "_stray"},
          64'(nstray), 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn;
      sel   = 1'b0;
      rstn  = 1'b0;
      start = 1'b0;
      cfg   = '0;
      mask  = '0;
      repeat (3) @(negedge clk);
      chk("rst_data", 64'(o_data), 64'd0);
      chk("rst_addr", 64'(o_addr), 64'd0);
      chk("rst_wr", 64'(o_wr), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      run(64'hA5123456789ABCDE, 8'h01,
          12, 1'b0, 1'b0);
      verify("single", 64'hA5123456789ABCDE,
             8'h01, 2, 4, 2);

      run(64'h0011223344556677, 8'hFF,
          70, 1'b0, 1'b0);
      verify("full", 64'h0011223344556677,
             8'hFF, 2, 4, 2);
      chk("idle_data", 64'(o_data), 64'h77);
      chk("idle_addr", 64'(o_addr), 64'd7);

      run(64'h0102030405060708, 8'h84,
          20, 1'b0, 1'b1);
      verify("sparse", 64'h0102030405060708,
             8'h84, 2, 4, 2);

      run(64'hDEADBEEFCAFEF00D, 8'h00,
          5, 1'b0, 1'b0);
      verify("zero", 64'hDEADBEEFCAFEF00D,
             8'h00, 2, 4, 2);

      run(64'h8877665544332211, 8'hFF,
          66, 1'b1, 1'b0);
      verify("held", 64'h8877665544332211,
             8'hFF, 2, 4, 2);
      @(negedge clk);
      chk("held_restart", 64'(o_busy), 64'd0);

      run(64'h1020304050607080, 8'hFF,
          28, 1'b0, 1'b0);
      chk("pre_rst_wr", 64'(o_wr), 64'd1);
      chk("pre_rst_addr", 64'(o_addr), 64'd3);
      rstn = 1'b0;
      @(negedge clk);
      chk("mid_rst_wr", 64'(o_wr), 64'd0);
      chk("mid_rst_busy", 64'(o_busy), 64'd0);
      chk("mid_rst_data", 64'(o_data), 64'd0);
      chk("mid_rst_addr", 64'(o_addr), 64'd0);
      chk("mid_rst_done", 64'(o_done), 64'd0);
      rstn = 1'b1;
      dn = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (o_done) dn++;
      end
      chk("abort_no_done", 64'(dn), 64'd0);

      run(64'h5A00000000000000, 8'h01,
          12, 1'b0, 1'b0);
      verify("after_rst", 64'h5A00000000000000,
             8'h01, 2, 4, 2);

      sel = 1'b1;
      repeat (2) @(negedge clk);
      run(64'h0123456789ABCDEF, 8'hFF,
          44, 1'b0, 1'b0);
      verify("sweep", 64'h0123456789ABCDEF,
             8'hFF, 1, 3, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
